// File: rtl/calc_key_entry.sv
// Keypad sequencer for the 4-digit BCD calculator: builds operands A and B from key strobes,
// latches the operator, captures the ALU result on '=' and selects what the display shows.
module calc_key_entry #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    input  logic [4*DIGITS-1:0]   alu_bcd_out,
    input  logic                  alu_special,
    output logic [4*DIGITS-1:0]   bcd1,
    output logic [4*DIGITS-1:0]   bcd2,
    output logic [1:0]            op_selected,
    output logic [4*DIGITS-1:0]   display_bcd,
    output logic                  display_neg,
    output logic                  result_valid,
    output logic [1:0]            entry_state
);

    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIGITS);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [3:0] K_ADD = 4'hA;
    localparam logic [3:0] K_SUB = 4'hB;
    localparam logic [3:0] K_EQ  = 4'hC;
    localparam logic [3:0] K_CE  = 4'hD;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;

    typedef enum logic [1:0] {
        ENTER_A     = 2'b00,
        ENTER_B     = 2'b01,
        SHOW_RESULT = 2'b10
    } state_t;

    state_t           state_q, state_n;
    logic [W-1:0]     bcd1_q, bcd1_n;
    logic [W-1:0]     bcd2_q, bcd2_n;
    logic [1:0]       op_q, op_n;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_n;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_n;
    logic [W-1:0]     res_q, res_n;
    logic             res_neg_q, res_neg_n;

    logic       is_digit, is_op, is_eq, is_ce;
    logic [1:0] key_op;

    // A digit is taken unless the operand is full or it would be a leading zero.
    function automatic logic accept_digit(input logic [CNT_W-1:0] cnt, input logic [3:0] d);
        return (cnt != CNT_FULL) && !((cnt == CNT_ZERO) && (d == 4'd0));
    endfunction

    function automatic logic [W-1:0] shift_digit(input logic [W-1:0] operand, input logic [3:0] d);
        return {operand[W-5:0], d};
    endfunction

    always_comb begin
        is_digit = key_valid && (key_code <= 4'd9);
        is_op    = key_valid && ((key_code == K_ADD) || (key_code == K_SUB));
        is_eq    = key_valid && (key_code == K_EQ);
        is_ce    = key_valid && (key_code == K_CE);
        key_op   = (key_code == K_ADD) ? OP_ADD : OP_SUB;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q   <= ENTER_A;
            bcd1_q    <= '0;
            bcd2_q    <= '0;
            op_q      <= OP_NONE;
            cnt_a_q   <= CNT_ZERO;
            cnt_b_q   <= CNT_ZERO;
            res_q     <= '0;
            res_neg_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            bcd1_q    <= bcd1_n;
            bcd2_q    <= bcd2_n;
            op_q      <= op_n;
            cnt_a_q   <= cnt_a_n;
            cnt_b_q   <= cnt_b_n;
            res_q     <= res_n;
            res_neg_q <= res_neg_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        bcd1_n    = bcd1_q;
        bcd2_n    = bcd2_q;
        op_n      = op_q;
        cnt_a_n   = cnt_a_q;
        cnt_b_n   = cnt_b_q;
        res_n     = res_q;
        res_neg_n = res_neg_q;

        if (is_ce) begin
            state_n   = ENTER_A;
            bcd1_n    = '0;
            bcd2_n    = '0;
            op_n      = OP_NONE;
            cnt_a_n   = CNT_ZERO;
            cnt_b_n   = CNT_ZERO;
            res_n     = '0;
            res_neg_n = 1'b0;
        end else begin
            case (state_q)
                ENTER_A: begin
                    if (is_digit && accept_digit(cnt_a_q, key_code)) begin
                        bcd1_n  = shift_digit(bcd1_q, key_code);
                        cnt_a_n = cnt_a_q + CNT_ONE;
                    end else if (is_op) begin
                        op_n    = key_op;
                        bcd2_n  = '0;
                        cnt_b_n = CNT_ZERO;
                        state_n = ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (is_digit && accept_digit(cnt_b_q, key_code)) begin
                        bcd2_n  = shift_digit(bcd2_q, key_code);
                        cnt_b_n = cnt_b_q + CNT_ONE;
                    end else if (is_op && (cnt_b_q == CNT_ZERO)) begin
                        op_n = key_op;
                    end else if (is_eq) begin
                        res_n     = alu_bcd_out;
                        res_neg_n = alu_special;
                        state_n   = SHOW_RESULT;
                    end
                end
                SHOW_RESULT: begin
                    if (is_digit) begin
                        bcd1_n  = {{(W-4){1'b0}}, key_code};
                        cnt_a_n = (key_code != 4'd0) ? CNT_ONE : CNT_ZERO;
                        bcd2_n  = '0;
                        cnt_b_n = CNT_ZERO;
                        op_n    = OP_NONE;
                        state_n = ENTER_A;
                    end else if (is_op && !res_neg_q) begin
                        // Chaining: the positive result becomes a full operand A.
                        bcd1_n  = res_q;
                        cnt_a_n = CNT_FULL;
                        bcd2_n  = '0;
                        cnt_b_n = CNT_ZERO;
                        op_n    = key_op;
                        state_n = ENTER_B;
                    end
                end
                default: begin
                    state_n = ENTER_A;
                end
            endcase
        end
    end

    always_comb begin
        display_bcd  = bcd1_q;
        display_neg  = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            ENTER_B: begin
                display_bcd = (cnt_b_q != CNT_ZERO) ? bcd2_q : bcd1_q;
            end
            SHOW_RESULT: begin
                display_bcd  = res_q;
                display_neg  = res_neg_q;
                result_valid = 1'b1;
            end
            default: begin
                display_bcd = bcd1_q;
            end
        endcase
    end

    assign bcd1        = bcd1_q;
    assign bcd2        = bcd2_q;
    assign op_selected = op_q;
    assign entry_state = state_q;

endmodule

// File: tb/tb_calc_key_entry.sv
// Scoreboard bench for calc_key_entry: directed key sequences push expected snapshots, a monitor
// compares them the cycle after each sampled strobe; a behavioural BCD ALU closes the loop.
module tb_calc_key_entry;

    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'hF;
    logic [15:0] alu_bcd_out;
    logic        alu_special;
    logic [15:0] bcd1, bcd2, display_bcd;
    logic [1:0]  op_selected, entry_state;
    logic        display_neg, result_valid;

    calc_key_entry #(.DIGITS(4)) dut (
        .clk(clk), .clear(clear), .key_valid(key_valid), .key_code(key_code),
        .alu_bcd_out(alu_bcd_out), .alu_special(alu_special),
        .bcd1(bcd1), .bcd2(bcd2), .op_selected(op_selected),
        .display_bcd(display_bcd), .display_neg(display_neg),
        .result_valid(result_valid), .entry_state(entry_state)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] ADD = 4'hA, SUB = 4'hB, EQ = 4'hC, CE = 4'hD, NOP = 4'hE;

    function automatic int bcd2int(input logic [15:0] v);
        return v[15:12] * 1000 + v[11:8] * 100 + v[7:4] * 10 + v[3:0];
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        int m;
        logic [15:0] r;
        m = v % 10000;
        r[15:12] = 4'(m / 1000);
        r[11:8]  = 4'((m / 100) % 10);
        r[7:4]   = 4'((m / 10) % 10);
        r[3:0]   = 4'(m % 10);
        return r;
    endfunction

    // Behavioural ALU: magnitude of A op B with a sign flag for negative differences.
    function automatic logic [16:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [1:0] op);
        int ia, ib;
        ia = bcd2int(a);
        ib = bcd2int(b);
        if (op == 2'b10) begin
            if (ia >= ib) return {1'b0, int2bcd(ia - ib)};
            else          return {1'b1, int2bcd(ib - ia)};
        end
        return {1'b0, int2bcd(ia + ib)};
    endfunction

    always_comb {alu_special, alu_bcd_out} = alu_model(bcd1, bcd2, op_selected);

    typedef struct {
        string       nm;
        logic [15:0] b1;
        logic [15:0] b2;
        logic [15:0] d;
        logic [1:0]  op;
        logic [1:0]  st;
        logic        neg;
        logic        rv;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_chk = 0;
    int   n_fail = 0;
    logic pend = 1'b0;

    task automatic check(input string nm, input string fld, input logic [15:0] act,
                         input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, exp);
        end
    endtask

    always @(posedge clk) pend <= key_valid || clear;

    always @(negedge clk) begin
        if (pend) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard_underflow actual=empty expected=entry");
            end else begin
                e = q.pop_front();
                check(e.nm, "bcd1", bcd1, e.b1);
                check(e.nm, "bcd2", bcd2, e.b2);
                check(e.nm, "op", {14'd0, op_selected}, {14'd0, e.op});
                check(e.nm, "display_bcd", display_bcd, e.d);
                check(e.nm, "display_neg", {15'd0, display_neg}, {15'd0, e.neg});
                check(e.nm, "result_valid", {15'd0, result_valid}, {15'd0, e.rv});
                check(e.nm, "entry_state", {14'd0, entry_state}, {14'd0, e.st});
            end
        end
    end

    task automatic key(input logic [3:0] c, input string nm, input logic [15:0] b1,
                       input logic [15:0] b2, input logic [1:0] op, input logic [15:0] d,
                       input logic neg, input logic rv, input logic [1:0] st);
        @(posedge clk);
        #1;
        key_valid = 1'b1;
        key_code  = c;
        q.push_back('{nm, b1, b2, d, op, st, neg, rv});
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 4'hF;
    endtask

    task automatic do_clear(input string nm, input logic with_key);
        @(posedge clk);
        #1;
        clear     = 1'b1;
        key_valid = with_key;
        key_code  = 4'h9;
        q.push_back('{nm, 16'h0, 16'h0, 16'h0, 2'b00, 2'b00, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        clear     = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'hF;
    endtask

    initial begin
        do_clear("reset", 1'b0);
        // Digit accumulation, fifth digit dropped
        key(4'd1, "a_d1", 16'h0001, 16'h0, 2'b00, 16'h0001, 0, 0, 2'b00);
        key(4'd2, "a_d2", 16'h0012, 16'h0, 2'b00, 16'h0012, 0, 0, 2'b00);
        key(4'd3, "a_d3", 16'h0123, 16'h0, 2'b00, 16'h0123, 0, 0, 2'b00);
        key(4'd4, "a_d4", 16'h1234, 16'h0, 2'b00, 16'h1234, 0, 0, 2'b00);
        key(4'd5, "a_d5_drop", 16'h1234, 16'h0, 2'b00, 16'h1234, 0, 0, 2'b00);
        key(NOP, "a_nop", 16'h1234, 16'h0, 2'b00, 16'h1234, 0, 0, 2'b00);
        key(EQ, "a_eq_ign", 16'h1234, 16'h0, 2'b00, 16'h1234, 0, 0, 2'b00);

        // Leading zeros, then 7 + 9 = 16
        do_clear("clear1", 1'b0);
        key(4'd0, "lz0", 16'h0000, 16'h0, 2'b00, 16'h0000, 0, 0, 2'b00);
        key(4'd0, "lz1", 16'h0000, 16'h0, 2'b00, 16'h0000, 0, 0, 2'b00);
        key(4'd7, "lz7", 16'h0007, 16'h0, 2'b00, 16'h0007, 0, 0, 2'b00);
        key(ADD, "add_op", 16'h0007, 16'h0, 2'b01, 16'h0007, 0, 0, 2'b01);
        key(4'd9, "b_d9", 16'h0007, 16'h0009, 2'b01, 16'h0009, 0, 0, 2'b01);
        key(EQ, "eq_16", 16'h0007, 16'h0009, 2'b01, 16'h0016, 0, 1, 2'b10);

        // 12 - 45 = -33, then '+' ignored on a negative result
        key(4'd1, "sr_d1", 16'h0001, 16'h0, 2'b00, 16'h0001, 0, 0, 2'b00);
        key(4'd2, "sr_d2", 16'h0012, 16'h0, 2'b00, 16'h0012, 0, 0, 2'b00);
        key(SUB, "sub_op", 16'h0012, 16'h0, 2'b10, 16'h0012, 0, 0, 2'b01);
        key(4'd4, "b_d4", 16'h0012, 16'h0004, 2'b10, 16'h0004, 0, 0, 2'b01);
        key(4'd5, "b_d5", 16'h0012, 16'h0045, 2'b10, 16'h0045, 0, 0, 2'b01);
        key(EQ, "eq_neg33", 16'h0012, 16'h0045, 2'b10, 16'h0033, 1, 1, 2'b10);
        key(ADD, "neg_chain_ign", 16'h0012, 16'h0045, 2'b10, 16'h0033, 1, 1, 2'b10);
        key(EQ, "no_repeat_eq", 16'h0012, 16'h0045, 2'b10, 16'h0033, 1, 1, 2'b10);

        // Operator replacement before any B digit, ignored afterwards
        key(4'd5, "sr_d5", 16'h0005, 16'h0, 2'b00, 16'h0005, 0, 0, 2'b00);
        key(ADD, "op_add", 16'h0005, 16'h0, 2'b01, 16'h0005, 0, 0, 2'b01);
        key(SUB, "op_replace", 16'h0005, 16'h0, 2'b10, 16'h0005, 0, 0, 2'b01);
        key(4'd3, "b_d3", 16'h0005, 16'h0003, 2'b10, 16'h0003, 0, 0, 2'b01);
        key(ADD, "op_locked", 16'h0005, 16'h0003, 2'b10, 16'h0003, 0, 0, 2'b01);

        // CE key, 8 + 2 = 10, chain 10 - 3 = 7, then a fresh digit
        key(CE, "ce_key", 16'h0, 16'h0, 2'b00, 16'h0, 0, 0, 2'b00);
        key(4'd8, "c_d8", 16'h0008, 16'h0, 2'b00, 16'h0008, 0, 0, 2'b00);
        key(ADD, "c_add", 16'h0008, 16'h0, 2'b01, 16'h0008, 0, 0, 2'b01);
        key(4'd2, "c_d2", 16'h0008, 16'h0002, 2'b01, 16'h0002, 0, 0, 2'b01);
        key(EQ, "eq_10", 16'h0008, 16'h0002, 2'b01, 16'h0010, 0, 1, 2'b10);
        key(SUB, "chain_sub", 16'h0010, 16'h0, 2'b10, 16'h0010, 0, 0, 2'b01);
        key(4'd3, "chain_d3", 16'h0010, 16'h0003, 2'b10, 16'h0003, 0, 0, 2'b01);
        key(EQ, "eq_7", 16'h0010, 16'h0003, 2'b10, 16'h0007, 0, 1, 2'b10);
        key(4'd4, "new_d4", 16'h0004, 16'h0, 2'b00, 16'h0004, 0, 0, 2'b00);

        // Mid-entry CE, then clear colliding with a digit strobe
        key(4'd1, "m_d1", 16'h0041, 16'h0, 2'b00, 16'h0041, 0, 0, 2'b00);
        key(4'd2, "m_d2", 16'h0412, 16'h0, 2'b00, 16'h0412, 0, 0, 2'b00);
        key(CE, "ce_mid", 16'h0, 16'h0, 2'b00, 16'h0, 0, 0, 2'b00);
        key(4'd1, "n_d1", 16'h0001, 16'h0, 2'b00, 16'h0001, 0, 0, 2'b00);
        key(4'd2, "n_d2", 16'h0012, 16'h0, 2'b00, 16'h0012, 0, 0, 2'b00);
        do_clear("clear_prio", 1'b1);

        repeat (3) @(posedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/calc_key_entry.md
Name: calc_key_entry

Overview:
- Keypad-side operand/operator sequencer for the 4-digit BCD calculator; drives the combinational BCD ALU's operand and op inputs.
- Accumulates up to 4 decimal digits per operand from single-cycle key strobes and latches the operator.
- On '=' captures the ALU result and sign.
- Provides the value and sign the 7-segment display path must show.

Parameters:
- DIGITS, 4: max digits per operand; operand width is 4*DIGITS bits (16 at default).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- clear  input  1  synchronous active-high reset.
- key_valid  input  1  one-cycle strobe; key_code is sampled only when high.
- key_code  input  4  0x0-0x9 = digit; 0xA = '+'; 0xB = '-'; 0xC = '='; 0xD = CE; 0xE/0xF = ignored.
- alu_bcd_out  input  16  ALU result in BCD, combinational from bcd1/bcd2/op_selected.
- alu_special  input  1  ALU sign flag; 1 = subtraction result is negative.
- bcd1  output  16  operand A, BCD, LS digit in [3:0].
- bcd2  output  16  operand B, BCD.
- op_selected  output  2  01 = add, 10 = sub, 00 = none.
- display_bcd  output  16  value to display.
- display_neg  output  1  minus sign for the display.
- result_valid  output  1  high while in SHOW_RESULT.
- entry_state  output  2  00 = ENTER_A, 01 = ENTER_B, 10 = SHOW_RESULT.

Behaviour:
- Reset and CE behave identically:
  - clear=1 at a clock edge, or a CE key in any state, sets: state ENTER_A, bcd1=0, bcd2=0, op_selected=00, digit count=0, result register=0, result sign=0.
  - Outputs after reset: display_bcd=0, display_neg=0, result_valid=0, entry_state=00.
  - clear has priority over key_valid in the same cycle.
- All key effects are registered and visible the cycle after the edge that sampled key_valid. key_valid=0 means hold all state.
- Digit entry (ENTER_A updates bcd1, ENTER_B updates bcd2):
  - count<DIGITS: operand <= {operand[11:0], digit}, count+1.
  - count==DIGITS: digit ignored, no wrap.
  - Leading zero: digit 0 with count==0 leaves the operand at 0 and count at 0.
- ENTER_A:
  - '+' sets op 01, '-' sets op 10; then go to ENTER_B with bcd2=0 and count=0.
  - '=' is ignored.
- ENTER_B:
  - Op key with count==0 replaces op_selected, no state change.
  - Op key with count>0 is ignored.
  - '=' samples alu_bcd_out and alu_special into the result register and sign on the same edge, then goes to SHOW_RESULT. bcd1, bcd2 and op are held.
- SHOW_RESULT:
  - Digit d: bcd1=d (count=1, or 0 if d=0), bcd2=0, op=00, go to ENTER_A.
  - Op key with result sign=0 chains: bcd1=result, count=DIGITS, bcd2=0, op set, go to ENTER_B.
  - Op key with result sign=1 is ignored; negative values cannot be re-entered.
  - '=' is ignored; no repeat-equals.
- display_bcd / display_neg, combinational from registered state:
  - ENTER_A: bcd1 / 0.
  - ENTER_B: bcd2 if count>0, else bcd1 / 0.
  - SHOW_RESULT: result register / result sign.
- Width rule: results above 9999 are not detected here. The captured value is whatever the ALU produces.
- Codes 0xE/0xF are no-ops in every state.

Test Plan:
- Reset, then keys 1,2,3,4,5 -> bcd1=0x1234 (5th digit dropped), display_bcd=0x1234, entry_state=00.
- Keys 0,0,7 -> bcd1=0x0007, count=1. Then '+',9,'=' with ALU model -> result_valid=1, display_bcd=0x0016, display_neg=0.
- Keys 1,2,'-',4,5,'=' -> bcd2=0x0045, op=10; ALU returns 0x0033 with special=1 -> display_bcd=0x0033, display_neg=1. Then '+' -> ignored, state stays 10.
- Keys 5,'+','-' -> op_selected=10, entry_state=01. Then 3,'+' -> op stays 10.
- 8,'+',2,'=' gives result 0x0010. Then '-',3 -> bcd1=0x0010, op=10, bcd2=0x0003. Then 4 from SHOW_RESULT after '=' -> bcd1=0x0004, op=00.
- Mid-entry 1,2 then key_valid with CE -> all zero next cycle. Repeat with clear and key_valid (digit 9) in the same cycle -> bcd1=0.
